// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared FSM encoding, size defaults and address-field helpers for the instruction cache.
package inst_cache_pkg;

   typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

   localparam int LINES_DEF = 16;
   localparam int WPL_DEF   = 4;
   localparam int BYTE_W    = 2;

   function automatic int off_w(input int wpl);
      return BYTE_W + $clog2(wpl);
   endfunction

   function automatic int tag_lsb(input int lines, input int wpl);
      return off_w(wpl) + $clog2(lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped tag/valid/data storage, one combinational read port and one write port.
module icache_array
   import inst_cache_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int WPL   = WPL_DEF,
   parameter int TW    = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clr,
   input  logic [$clog2(LINES)-1:0] i_rd_idx,
   input  logic [$clog2(WPL)-1:0]   i_rd_word,
   output logic                     o_rd_valid,
   output logic [TW-1:0]            o_rd_tag,
   output logic [31:0]              o_rd_data,
   input  logic                     i_we,
   input  logic                     i_fill,
   input  logic [$clog2(LINES)-1:0] i_wr_idx,
   input  logic [$clog2(WPL)-1:0]   i_wr_word,
   input  logic [31:0]              i_wr_data,
   input  logic [TW-1:0]            i_wr_tag
);

   logic [LINES-1:0] r_valid;
   logic [TW-1:0]    r_tag  [LINES];
   logic [31:0]      r_data [LINES][WPL];

   always_ff @(posedge clk or posedge rst)
      if (rst) r_valid <= '0;
      else if (i_clr) r_valid <= '0;
      else if (i_fill) r_valid[i_wr_idx] <= 1'b1;

   // tag and data are deliberately left unreset; valid alone gates their use
   always_ff @(posedge clk) begin
      if (i_we) r_data[i_wr_idx][i_wr_word] <= i_wr_data;
      if (i_fill) r_tag[i_wr_idx] <= i_wr_tag;
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache with a blocking line-refill FSM.
// A miss latches the line and bursts WPL words from memory before hit is re-evaluated.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int WPL   = WPL_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        inv,
   output logic [31:0] ins,
   output logic        hit,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_valid
);

   localparam int WW = $clog2(WPL);
   localparam int IW = $clog2(LINES);
   localparam int OW = off_w(WPL);
   localparam int TL = tag_lsb(LINES, WPL);
   localparam int TW = 32 - TL;

   state_t          r_state, w_next;
   logic [31:OW]    r_line;
   logic [IW-1:0]   r_idx;
   logic [TW-1:0]   r_tag;
   logic [WW-1:0]   r_cnt;
   logic [IW-1:0]   w_idx;
   logic [WW-1:0]   w_word;
   logic [TW-1:0]   w_tag;
   logic            w_rd_valid;
   logic [TW-1:0]   w_rd_tag;
   logic [31:0]     w_rd_data;
   logic            w_we, w_last, w_fill, w_miss;
   logic            w_unused;

   assign w_idx    = pc[TL-1:OW];
   assign w_word   = pc[OW-1:BYTE_W];
   assign w_tag    = pc[31:TL];
   assign w_unused = &{1'b0, pc[BYTE_W-1:0]};

   assign hit      = r_state == IDLE && w_rd_valid && w_rd_tag == w_tag;
   assign ins      = hit ? w_rd_data : 32'h0;
   assign mem_req  = r_state == REFILL;
   assign mem_addr = mem_req ? {r_line, r_cnt, {BYTE_W{1'b0}}} : 32'h0;
   assign w_miss   = r_state == IDLE && !hit && !inv;
   assign w_we     = mem_req && mem_valid && !inv;
   assign w_last   = r_cnt == WW'(WPL - 1);
   assign w_fill   = w_we && w_last;

   always_comb begin
      w_next = r_state;
      w_next = inv ? IDLE :
               w_miss ? REFILL :
               (r_state == REFILL && mem_valid && w_last) ? FILL_DONE :
               r_state == FILL_DONE ? IDLE : r_state;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_line  <= '0;
         r_idx   <= '0;
         r_tag   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (inv) r_cnt <= '0;
         else if (w_miss) begin
            r_line <= pc[31:OW];
            r_idx  <= w_idx;
            r_tag  <= w_tag;
            r_cnt  <= '0;
         end else if (w_we) r_cnt <= r_cnt + 1'b1;
      end

   icache_array #(.LINES(LINES), .WPL(WPL), .TW(TW)) u_array (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (inv),
      .i_rd_idx  (w_idx),
      .i_rd_word (w_word),
      .o_rd_valid(w_rd_valid),
      .o_rd_tag  (w_rd_tag),
      .o_rd_data (w_rd_data),
      .i_we      (w_we),
      .i_fill    (w_fill),
      .i_wr_idx  (r_idx),
      .i_wr_word (r_cnt),
      .i_wr_data (mem_data),
      .i_wr_tag  (r_tag)
   );

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized fetch stream against a line-level cache model with a miss-penalty timing rule.
module tb_inst_cache;

   localparam int WPL = 4;

   logic        clk = 1'b0, rst = 1'b1, inv = 1'b0, mem_valid = 1'b0;
   logic [31:0] pc = 32'h0, mem_data = 32'h0;
   logic [31:0] ins, mem_addr;
   logic        hit, mem_req;

   int          n_checks = 0, n_fail = 0;
   int          stall_pct = 0, hold_at = -1;
   bit          mv [16];
   logic [23:0] mt [16];
   int          cyc;
   bit          missed;

   inst_cache dut (
      .clk(clk), .rst(rst), .pc(pc), .inv(inv), .ins(ins), .hit(hit),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [1:0] w;
      w = a[3:2];
      return (a[31:4] == 28'h10) ? (32'(w) + 32'd1) * 32'h11 : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic clear_model();
      foreach (mv[i]) mv[i] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; inv = 1'b0; mem_valid = 1'b0;
      #1 clear_model();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic inv_all();
      @(negedge clk);
      inv = 1'b1;
      #1;
      @(negedge clk);
      inv = 1'b0;
      #1 clear_model();
   endtask

   // Present pc=a and follow it to a hit; miss cost must be WPL+2 plus every stalled refill cycle.
   task automatic fetch(input logic [31:0] a, output int n, output bit m);
      logic [31:0] wa, base;
      int stalls, words, held;
      bit v;
      wa = {a[31:2], 2'b00};
      base = {a[31:4], 4'h0};
      n = 0; stalls = 0; words = 0; held = 0;
      pc = a; mem_valid = 1'b0;
      #1;
      m = !(mv[a[7:4]] && mt[a[7:4]] == a[31:8]);
      if (!m) begin
         check("hit_now", hit, 1);
         check("ins_hit", ins, mem_word(wa));
         check("noreq_hit", mem_req, 0);
         @(negedge clk);
         #1;
      end else begin
         check("miss_now", hit, 0);
         while (!hit && n < 100) begin
            if (mem_req) begin
               check("mem_addr", mem_addr, base + 32'(4 * words));
               if (hold_at == words && held < 3) begin v = 1'b0; held++; end
               else v = $urandom_range(0, 99) >= stall_pct;
               mem_data = v ? mem_word(base + 32'(4 * words)) : $urandom;
               if (v) words++; else stalls++;
               pc = ($urandom_range(0, 3) == 0) ? $urandom : a;
            end else begin
               v = 1'($urandom_range(0, 1));
               mem_data = $urandom;
               pc = a;
            end
            mem_valid = v;
            @(negedge clk);
            #1 n++;
         end
         mem_valid = 1'b0;
         check("hit_after_fill", hit, 1);
         check("penalty", 32'(n), 32'(WPL + 2 + stalls));
         check("ins_fill", ins, mem_word(wa));
         mv[a[7:4]] = 1'b1;
         mt[a[7:4]] = a[31:8];
      end
   endtask

   initial begin
      pc = 32'h40;
      #1;
      check("rst_hit", hit, 0);
      check("rst_ins", ins, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      #1;
      fetch(32'h40, cyc, missed);
      check("first_miss", 32'(missed), 1);

      fetch(32'h100, cyc, missed);
      check("penalty_6", 32'(cyc), 6);
      fetch(32'h10C, cyc, missed);
      check("hit_10c", 32'(missed), 0);
      fetch(32'h104, cyc, missed);

      inv_all();
      hold_at = 1;
      fetch(32'h100, cyc, missed);
      hold_at = -1;
      check("penalty_9", 32'(cyc), 9);
      fetch(32'h108, cyc, missed);
      check("hit_108", 32'(missed), 0);

      fetch(32'h200, cyc, missed);
      check("conflict_miss", 32'(missed), 1);
      fetch(32'h100, cyc, missed);
      check("evicted_miss", 32'(missed), 1);

      inv_all();
      pc = 32'h300;
      #1;
      check("inv_miss", hit, 0);
      @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         mem_valid = 1'b1;
         mem_data = mem_word(32'h300 + 32'(4 * k));
         inv = (k == 3);
         @(negedge clk);
         #1;
      end
      check("inv_req", mem_req, 0);
      check("inv_noinstall", hit, 0);
      inv = 1'b0; mem_valid = 1'b0;
      @(negedge clk);
      #1;
      check("inv_remiss_req", mem_req, 1);
      check("inv_remiss_addr", mem_addr, 32'h300);
      do_reset();

      pc = 32'h500;
      #1;
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         mem_valid = 1'b1;
         mem_data = mem_word(32'h500 + 32'(4 * k));
         @(negedge clk);
         #1;
      end
      mem_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_req", mem_req, 0);
      check("abort_hit", hit, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_ins", ins, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_miss", hit, 0);
      @(negedge clk);
      #1;
      check("restart_req", mem_req, 1);
      check("restart_addr", mem_addr, 32'h500);
      do_reset();

      stall_pct = 30;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 14) == 0) inv_all();
         fetch((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
               32'($urandom_range(0, 15)), cyc, missed);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter LINES, default 16: number of direct-mapped cache lines.
REQ-002 Parameter WPL, default 4: 32-bit words per line.
REQ-003 Port clk  input  1: single clock; all state updates on the posedge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port pc  input  32: fetch byte address.
REQ-006 Port inv  input  1: synchronous invalidate-all request.
REQ-007 Port ins  output  32: fetched instruction; feeds the IF/ID register.
REQ-008 Port hit  output  1: ins is valid this cycle; acts as the IF/ID write enable.
REQ-009 Port mem_req  output  1: refill burst active.
REQ-010 Port mem_addr  output  32: word address of the refill word requested.
REQ-011 Port mem_data  input  32: refill data.
REQ-012 Port mem_valid  input  1: mem_data carries the word at mem_addr this cycle.

Function
REQ-013 Address split (defaults): pc[1:0] ignored; pc[3:2] word select; pc[7:4] index; pc[31:8] tag. Widths scale with log2 of WPL and LINES.
REQ-014 hit SHALL be combinational: state==IDLE, valid[index]==1 and tag[index]==pc tag.
REQ-015 ins SHALL equal data[index][word] when hit==1, and 32'h0 otherwise.
REQ-016 The FSM SHALL have three states: IDLE, REFILL, FILL_DONE.
REQ-017 IDLE -> REFILL on a miss (hit==0 with inv==0); latch line base {pc[31:4],4'b0}, latch index and tag, clear word counter.
REQ-018 In REFILL, mem_req SHALL be 1 and mem_addr SHALL be line base + 4*counter.
REQ-019 Each mem_valid==1 cycle in REFILL SHALL write mem_data to data[latched index][counter] and increment counter.
REQ-020 The counter SHALL be 2 bits and wrap 3 -> 0 on the final word.
REQ-021 When the WPL-th word is written, the FSM SHALL go to FILL_DONE and SHALL set valid and tag for the latched index on that same edge.
REQ-022 mem_valid==0 in REFILL SHALL hold the counter and data; there is no timeout.
REQ-023 FILL_DONE -> IDLE unconditionally after one cycle with mem_req==0; hit is re-evaluated on the current pc in IDLE.
REQ-024 Minimum miss penalty SHALL be WPL+2 cycles from the miss to hit==1.
REQ-025 A pc change during REFILL SHALL NOT alter the latched base, index or tag; the burst completes as started.
REQ-026 inv==1 SHALL clear all valid bits, force IDLE, zero the counter and drop mem_req on the next edge; it wins over a completing refill in the same cycle, so no line is installed.
REQ-027 mem_valid outside REFILL SHALL be ignored.

Reset
REQ-028 rst SHALL asynchronously force: state IDLE, all valid bits 0, counter 0, latched address 0.
REQ-029 Outputs during reset SHALL be: hit 0, ins 32'h0, mem_req 0, mem_addr 32'h0.
REQ-030 The tag and data arrays SHALL NOT be reset.
REQ-031 rst asserted mid-REFILL SHALL abort the burst; after release, the same pc misses again and restarts from word 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, LINES/WPL defaults, and the address-field width/offset constants.
REQ-033 One sub-module, icache_array, SHALL hold the tag/valid/data storage with one read port and one write port; the FSM and address logic live in inst_cache.

Verification
REQ-034 Reset, then pc=0x00000040 -> hit=0, mem_req=1, mem_addr=0x40.
REQ-035 Miss at 0x100; memory returns 4 words back-to-back (0x11,0x22,0x33,0x44) -> mem_addr steps 0x100/104/108/10C; hit=1 with ins=0x11 exactly 6 cycles after the miss; then pc=0x10C -> hit=1, ins=0x44 with no mem_req.
REQ-036 Same refill with mem_valid low for 3 cycles after word 1 -> counter holds; penalty becomes 9 cycles; data correct.
REQ-037 Line 0x100 installed, then pc=0x200 (same index 0, different tag) -> miss and refill; afterwards 0x100 misses (conflict eviction).
REQ-038 inv=1 asserted on the cycle the 4th word arrives -> no line installed, state IDLE; the next cycle misses again.
REQ-039 rst pulsed after word 2 of a refill -> mem_req=0 and hit=0 immediately; after release, the refill restarts at the line base.
